// File: rtl/pa_noc.sv
// -----------------------------------------------------------------------------
// pa_noc
// Shared NoC definitions for the network-interface blocks:
//   - coordinate and packet widths
//   - request/response packet layout (packed struct plus field bit positions)
//   - APB address bits that select the destination router
//   - requester FSM state encoding
// -----------------------------------------------------------------------------
package pa_noc;

  localparam int COORD_WIDTH      = 2;
  localparam int APB_PACKET_WIDTH = 77;
  localparam int TIMEOUT_WIDTH    = 16;

  // Packet field bit positions (LSB of each field, or the bit itself).
  localparam int PKT_DST_COL_LSB = 0;
  localparam int PKT_DST_ROW_LSB = 2;
  localparam int PKT_SRC_COL_LSB = 4;
  localparam int PKT_SRC_ROW_LSB = 6;
  localparam int PKT_IS_RESP_BIT = 8;
  localparam int PKT_WRITE_BIT   = 9;
  localparam int PKT_TAG_BIT     = 10;
  localparam int PKT_ERR_BIT     = 11;
  localparam int PKT_VALID_BIT   = 12;
  localparam int PKT_ADDR_LSB    = 13;
  localparam int PKT_DATA_LSB    = 45;

  // Destination router coordinates live in the top address bits.
  localparam int ADDR_ROW_MSB = 31;
  localparam int ADDR_ROW_LSB = 30;
  localparam int ADDR_COL_MSB = 29;
  localparam int ADDR_COL_LSB = 28;

  // Declared MSB first so the struct maps directly onto the packet vector.
  typedef struct packed {
    logic [31:0]            data;     // [76:45]
    logic [31:0]            addr;     // [44:13]
    logic                   valid;    // [12]
    logic                   err;      // [11]
    logic                   tag;      // [10]
    logic                   write;    // [9]
    logic                   is_resp;  // [8]
    logic [COORD_WIDTH-1:0] src_row;  // [7:6]
    logic [COORD_WIDTH-1:0] src_col;  // [5:4]
    logic [COORD_WIDTH-1:0] dst_row;  // [3:2]
    logic [COORD_WIDTH-1:0] dst_col;  // [1:0]
  } apb_packet_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } ni_state_t;

endpackage

// File: rtl/ni_timeout_counter.sv
// -----------------------------------------------------------------------------
// ni_timeout_counter
// Cycle counter that flags expiry on the LIMIT-th enabled cycle after a clear.
//   clk     : clock
//   rst     : asynchronous active-high reset
//   clear   : restart counting from zero (takes priority over enable)
//   enable  : count this cycle
//   expired : high during the enabled cycle in which the count equals LIMIT-1
// -----------------------------------------------------------------------------
module ni_timeout_counter
  import pa_noc::*;
#(
  parameter int LIMIT = 256,
  parameter int WIDTH = TIMEOUT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count_reg;

  // Saturate at LAST so a stalled enable never wraps into a false restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != LAST)) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign expired = enable && (count_reg == LAST);

endmodule

// File: rtl/ni_apb_requester.sv
// -----------------------------------------------------------------------------
// ni_apb_requester
// Network-interface requester stage in front of a router's local port. Acts
// as an APB completer: each APB transfer becomes one request packet into the
// router, and the matching response packet completes the transfer.
//   i_clk, i_arst            : clock, asynchronous active-high reset
//   i_psel/i_penable/i_pwrite: APB control from the local requester
//   i_paddr, i_pwdata        : APB address ([31:30] row, [29:28] col) and data
//   o_pready/o_prdata/o_pslverr : APB completion, all registered
//   o_apbPacket              : request packet to router local input (0 = idle)
//   i_apbPacket              : packets from router local output
// -----------------------------------------------------------------------------
module ni_apb_requester
  import pa_noc::*;
#(
  parameter int ROUTER_ROW     = 0,
  parameter int ROUTER_COL     = 0,
  parameter int GRID_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        i_clk,
  input  logic                        i_arst,
  input  logic                        i_psel,
  input  logic                        i_penable,
  input  logic                        i_pwrite,
  input  logic [31:0]                 i_paddr,
  input  logic [31:0]                 i_pwdata,
  output logic                        o_pready,
  output logic [31:0]                 o_prdata,
  output logic                        o_pslverr,
  output logic [APB_PACKET_WIDTH-1:0] o_apbPacket,
  input  logic [APB_PACKET_WIDTH-1:0] i_apbPacket
);

  localparam logic [COORD_WIDTH-1:0] OWN_ROW    = COORD_WIDTH'(ROUTER_ROW);
  localparam logic [COORD_WIDTH-1:0] OWN_COL    = COORD_WIDTH'(ROUTER_COL);
  localparam logic [COORD_WIDTH:0]   GRID_LIMIT = (COORD_WIDTH + 1)'(GRID_WIDTH);

  // State and datapath registers
  ni_state_t              state_reg,   state_next;
  logic [COORD_WIDTH-1:0] dst_row_reg, dst_row_next;
  logic [COORD_WIDTH-1:0] dst_col_reg, dst_col_next;
  logic                   write_reg,   write_next;
  logic                   tag_reg,     tag_next;
  apb_packet_t            pkt_reg,     pkt_next;
  logic [31:0]            prdata_reg,  prdata_next;
  logic                   pslverr_reg, pslverr_next;
  logic                   pready_reg,  pready_next;

  logic                   cnt_clear;
  logic                   cnt_enable;
  logic                   timeout_hit;

  // Address decode of the live APB request
  logic [COORD_WIDTH-1:0] req_row;
  logic [COORD_WIDTH-1:0] req_col;
  logic                   req_in_range;
  logic                   setup_phase;

  assign req_row      = i_paddr[ADDR_ROW_MSB:ADDR_ROW_LSB];
  assign req_col      = i_paddr[ADDR_COL_MSB:ADDR_COL_LSB];
  assign req_in_range = ({1'b0, req_row} < GRID_LIMIT) && ({1'b0, req_col} < GRID_LIMIT);
  assign setup_phase  = i_psel && !i_penable;

  // Response filter: only a valid response addressed to this node, coming
  // from the router we targeted and carrying the outstanding tag is taken.
  apb_packet_t rx;
  logic        resp_match;
  logic        unused_rx_fields;

  assign rx         = i_apbPacket;
  assign resp_match = rx.valid && rx.is_resp
                   && (rx.dst_row == OWN_ROW)     && (rx.dst_col == OWN_COL)
                   && (rx.src_row == dst_row_reg) && (rx.src_col == dst_col_reg)
                   && (rx.tag == tag_reg);
  assign unused_rx_fields = ^{rx.addr, rx.write};

  ni_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES),
    .WIDTH (TIMEOUT_WIDTH)
  ) u_timeout (
    .clk     (i_clk),
    .rst     (i_arst),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .expired (timeout_hit)
  );

  // Next-state and registered-output logic. Packet and completion outputs
  // default to zero so they are only non-zero in the cycle they are meant for.
  always_comb begin
    state_next   = state_reg;
    dst_row_next = dst_row_reg;
    dst_col_next = dst_col_reg;
    write_next   = write_reg;
    tag_next     = tag_reg;
    pkt_next     = '0;
    prdata_next  = '0;
    pslverr_next = 1'b0;
    pready_next  = 1'b0;
    cnt_clear    = 1'b0;
    cnt_enable   = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (setup_phase) begin
          dst_row_next = req_row;
          dst_col_next = req_col;
          write_next   = i_pwrite;
          if (req_in_range) begin
            // Packet register is loaded now so it is on the wire during SEND.
            pkt_next.data    = i_pwrite ? i_pwdata : 32'd0;
            pkt_next.addr    = i_paddr;
            pkt_next.valid   = 1'b1;
            pkt_next.err     = 1'b0;
            pkt_next.tag     = tag_reg;
            pkt_next.write   = i_pwrite;
            pkt_next.is_resp = 1'b0;
            pkt_next.src_row = OWN_ROW;
            pkt_next.src_col = OWN_COL;
            pkt_next.dst_row = req_row;
            pkt_next.dst_col = req_col;
            state_next       = SEND;
          end else begin
            state_next = DONE;
          end
        end
      end

      SEND: begin
        cnt_clear  = 1'b1;
        state_next = WAIT;
      end

      WAIT: begin
        cnt_enable = 1'b1;
        // Checked before the timeout so a same-cycle response wins.
        if (resp_match) begin
          prdata_next  = write_reg ? 32'd0 : rx.data;
          pslverr_next = rx.err;
          pready_next  = 1'b1;
          state_next   = DONE;
        end else if (timeout_hit) begin
          pslverr_next = 1'b1;
          pready_next  = 1'b1;
          state_next   = DONE;
        end
      end

      DONE: begin
        if (pready_reg) begin
          tag_next   = ~tag_reg;
          state_next = IDLE;
        end else begin
          // Entered straight from IDLE on an undecodable address: the
          // error completion is presented one cycle after entry.
          pslverr_next = 1'b1;
          pready_next  = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_reg   <= IDLE;
      dst_row_reg <= '0;
      dst_col_reg <= '0;
      write_reg   <= 1'b0;
      tag_reg     <= 1'b0;
      pkt_reg     <= '0;
      prdata_reg  <= '0;
      pslverr_reg <= 1'b0;
      pready_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      dst_row_reg <= dst_row_next;
      dst_col_reg <= dst_col_next;
      write_reg   <= write_next;
      tag_reg     <= tag_next;
      pkt_reg     <= pkt_next;
      prdata_reg  <= prdata_next;
      pslverr_reg <= pslverr_next;
      pready_reg  <= pready_next;
    end
  end

  assign o_apbPacket = pkt_reg;
  assign o_prdata    = prdata_reg;
  assign o_pslverr   = pslverr_reg;
  assign o_pready    = pready_reg;

endmodule

// File: tb/tb_ni_apb_requester.sv
// -----------------------------------------------------------------------------
// tb_ni_apb_requester
// Scoreboard bench: expected request packets and expected completions are
// queued as each transfer is driven, and a negedge monitor pops and compares
// them whenever the DUT emits a packet or raises o_pready.
// -----------------------------------------------------------------------------
module tb_ni_apb_requester;

  localparam int PW = 77;

  logic          clk;
  logic          rst;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [31:0]   paddr;
  logic [31:0]   pwdata;
  logic          pready;
  logic [31:0]   prdata;
  logic          pslverr;
  logic [PW-1:0] req_pkt;
  logic [PW-1:0] rx_pkt;

  int n_checks = 0;
  int n_fails  = 0;

  logic [PW-1:0] exp_pkt_q[$];
  logic [32:0]   exp_cpl_q[$];
  logic          exp_tag;
  logic [PW-1:0] mon_pkt;
  logic [32:0]   mon_cpl;

  ni_apb_requester #(
    .ROUTER_ROW     (0),
    .ROUTER_COL     (0),
    .GRID_WIDTH     (3),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clk       (clk),
    .i_arst      (rst),
    .i_psel      (psel),
    .i_penable   (penable),
    .i_pwrite    (pwrite),
    .i_paddr     (paddr),
    .i_pwdata    (pwdata),
    .o_pready    (pready),
    .o_prdata    (prdata),
    .o_pslverr   (pslverr),
    .o_apbPacket (req_pkt),
    .i_apbPacket (rx_pkt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Packet layout built bit-by-bit from the field list.
  function automatic logic [PW-1:0] mk_pkt(input logic [31:0] data, input logic [31:0] addr,
                                           input logic valid, input logic err, input logic tag,
                                           input logic wr, input logic resp,
                                           input logic [1:0] srow, input logic [1:0] scol,
                                           input logic [1:0] drow, input logic [1:0] dcol);
    return {data, addr, valid, err, tag, wr, resp, srow, scol, drow, dcol};
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (req_pkt != '0) begin
        if (exp_pkt_q.size() == 0) begin
          check("pkt_unexpected", req_pkt, '0);
        end else begin
          mon_pkt = exp_pkt_q.pop_front();
          check("pkt", req_pkt, mon_pkt);
          $display("req  pkt=%h", req_pkt);
        end
      end
      if (pready) begin
        if (exp_cpl_q.size() == 0) begin
          check("pready_unexpected", pready, 1'b0);
        end else begin
          mon_cpl = exp_cpl_q.pop_front();
          check("cpl", {prdata, pslverr}, mon_cpl);
          $display("cpl  prdata=%h pslverr=%b", prdata, pslverr);
        end
      end else if ((prdata != '0) || pslverr) begin
        check("out_not_idle", {prdata, pslverr}, '0);
      end
    end
  end

  task automatic do_setup(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
  endtask

  task automatic send_resp(input logic [PW-1:0] p);
    @(posedge clk); #1;
    rx_pkt = p;
    @(posedge clk); #1;
    rx_pkt = '0;
  endtask

  task automatic end_xfer();
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rdata, input logic err);
    logic [1:0] r;
    logic [1:0] c;
    r = addr[31:30];
    c = addr[29:28];
    exp_pkt_q.push_back(mk_pkt(wr ? wdata : 32'd0, addr, 1'b1, 1'b0, exp_tag, wr, 1'b0,
                               2'd0, 2'd0, r, c));
    do_setup(wr, addr, wdata);
    @(negedge clk); check("pkt_latency", req_pkt[12], 1'b1);
    @(negedge clk); check("pkt_one_cycle", req_pkt[12], 1'b0);
    exp_cpl_q.push_back({wr ? 32'd0 : rdata, err});
    send_resp(mk_pkt(rdata, addr, 1'b1, err, exp_tag, wr, 1'b1, r, c, 2'd0, 2'd0));
    @(negedge clk); check("pready_latency", pready, 1'b1);
    end_xfer();
    @(negedge clk); check("pready_one_cycle", pready, 1'b0);
    exp_tag = ~exp_tag;
  endtask

  task automatic bad_addr(input logic [31:0] addr);
    exp_cpl_q.push_back({32'd0, 1'b1});
    do_setup(1'b0, addr, 32'd0);
    @(negedge clk);
    check("oor_pready_early", pready, 1'b0);
    check("oor_no_pkt", req_pkt, '0);
    @(negedge clk); check("oor_pready_latency", pready, 1'b1);
    end_xfer();
    @(negedge clk); check("oor_pready_one_cycle", pready, 1'b0);
    exp_tag = ~exp_tag;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n;
    bit  seen;
    logic old_tag;

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; rx_pkt = '0; exp_tag = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pready", pready, 1'b0);
    check("rst_prdata", prdata, 32'd0);
    check("rst_pslverr", pslverr, 1'b0);
    check("rst_pkt", req_pkt, '0);
    rst = 1'b0;

    // Read to (1,2), then write to (0,1) completing with an error
    xfer(1'b0, 32'h6000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0);
    xfer(1'b1, 32'h1000_0004, 32'h1234_5678, 32'hAAAA_5555, 1'b1);

    // Timeout: no response for a read to (2,1)
    old_tag = exp_tag;
    exp_pkt_q.push_back(mk_pkt(32'd0, 32'h9000_0000, 1'b1, 1'b0, exp_tag, 1'b0, 1'b0,
                               2'd0, 2'd0, 2'd2, 2'd1));
    exp_cpl_q.push_back({32'd0, 1'b1});
    do_setup(1'b0, 32'h9000_0000, 32'd0);
    @(negedge clk); check("to_pkt_latency", req_pkt[12], 1'b1);
    n = 0; seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (pready) seen = 1;
    end
    check("timeout_latency", n, 17);
    end_xfer();
    exp_tag = ~exp_tag;
    send_resp(mk_pkt(32'h5555_0000, 32'h9000_0000, 1'b1, 1'b0, old_tag, 1'b0, 1'b1,
                     2'd2, 2'd1, 2'd0, 2'd0));
    @(negedge clk); check("late_resp_dropped", pready, 1'b0);

    // Undecodable row (3) and column (3) with GRID_WIDTH=3
    bad_addr(32'hC000_0000);
    bad_addr(32'h3000_0000);

    // Filtered packets during WAIT, then the real response
    exp_pkt_q.push_back(mk_pkt(32'd0, 32'hA000_0000, 1'b1, 1'b0, exp_tag, 1'b0, 1'b0,
                               2'd0, 2'd0, 2'd2, 2'd2));
    do_setup(1'b0, 32'hA000_0000, 32'd0);
    @(negedge clk); check("ign_pkt_latency", req_pkt[12], 1'b1);
    @(negedge clk);
    send_resp(mk_pkt(32'h1, 32'hA000_0000, 1'b1, 1'b0, ~exp_tag, 1'b0, 1'b1, 2'd2, 2'd2, 2'd0, 2'd0));
    @(negedge clk); check("ign_wrong_tag", pready, 1'b0);
    send_resp(mk_pkt(32'h2, 32'hA000_0000, 1'b1, 1'b0, exp_tag, 1'b0, 1'b0, 2'd2, 2'd2, 2'd0, 2'd0));
    @(negedge clk); check("ign_not_resp", pready, 1'b0);
    send_resp(mk_pkt(32'h3, 32'hA000_0000, 1'b1, 1'b0, exp_tag, 1'b0, 1'b1, 2'd1, 2'd2, 2'd0, 2'd0));
    @(negedge clk); check("ign_wrong_src", pready, 1'b0);
    send_resp(mk_pkt(32'h4, 32'hA000_0000, 1'b1, 1'b0, exp_tag, 1'b0, 1'b1, 2'd2, 2'd2, 2'd0, 2'd1));
    @(negedge clk); check("ign_wrong_dst", pready, 1'b0);
    send_resp(mk_pkt(32'h5, 32'hA000_0000, 1'b0, 1'b0, exp_tag, 1'b0, 1'b1, 2'd2, 2'd2, 2'd0, 2'd0));
    @(negedge clk); check("ign_not_valid", pready, 1'b0);
    exp_cpl_q.push_back({32'hCAFE_0001, 1'b0});
    send_resp(mk_pkt(32'hCAFE_0001, 32'hA000_0000, 1'b1, 1'b0, exp_tag, 1'b0, 1'b1,
                     2'd2, 2'd2, 2'd0, 2'd0));
    @(negedge clk); check("ign_final_pready", pready, 1'b1);
    end_xfer();
    exp_tag = ~exp_tag;

    // Reset during WAIT aborts the transfer; a later matching response is dropped
    exp_pkt_q.push_back(mk_pkt(32'd0, 32'h5000_0000, 1'b1, 1'b0, exp_tag, 1'b0, 1'b0,
                               2'd0, 2'd0, 2'd1, 2'd1));
    do_setup(1'b0, 32'h5000_0000, 32'd0);
    @(negedge clk); check("rst_pkt_latency", req_pkt[12], 1'b1);
    @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_mid_pready", pready, 1'b0);
    check("rst_mid_prdata", prdata, 32'd0);
    check("rst_mid_pslverr", pslverr, 1'b0);
    check("rst_mid_pkt", req_pkt, '0);
    psel = 1'b0; penable = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_tag = 1'b0;
    send_resp(mk_pkt(32'h7777_7777, 32'h5000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                     2'd1, 2'd1, 2'd0, 2'd0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check("rst_no_pready", pready, 1'b0);
    end

    // Tag restarts at 0 after reset
    xfer(1'b0, 32'h1000_0008, 32'd0, 32'h0BAD_F00D, 1'b0);

    repeat (2) @(negedge clk);
    check("sb_pkt_left", exp_pkt_q.size(), 0);
    check("sb_cpl_left", exp_cpl_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
